// File: rtl/spi_master.sv
// SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, byte-stream host side.
// SS stays low across bytes until a byte flagged txLast has completed.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       sysClk,
    input  logic       rst,
    input  logic       txValid,
    input  logic [7:0] txData,
    input  logic       txLast,
    output logic       txReady,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    output logic       SPICLK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT_NEXT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    state_t     r_state, w_state;
    logic [7:0] r_div, w_div;
    logic [2:0] r_bit, w_bit;
    logic [7:0] r_tx, w_tx;
    logic [7:0] r_rx, w_rx;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_last, w_last;
    logic       r_sclk, w_sclk;
    logic       r_mosi, w_mosi;
    logic       r_ss, w_ss;

    logic       w_ready;
    logic       w_accept;
    logic       w_div_end;

    assign w_ready   = ~rst & ((r_state == IDLE) | (r_state == WAIT_NEXT));
    assign w_accept  = txValid & w_ready;
    assign w_div_end = (r_div == DIV_MAX);

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_bit      = r_bit;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_last     = r_last;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_ss       = r_ss;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state = SETUP;
                    w_div   = 8'd0;
                    w_tx    = txData;
                    w_last  = txLast;
                    w_ss    = 1'b0;
                end
            end
            SETUP: begin
                if (w_div_end) begin
                    w_state = SHIFT;
                    w_div   = 8'd0;
                    w_sclk  = 1'b0;
                    w_mosi  = r_tx[7];
                    w_tx    = {r_tx[6:0], 1'b0};
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            SHIFT: begin
                if (!w_div_end) begin
                    w_div = r_div + 8'd1;
                end else begin
                    w_div = 8'd0;
                    if (!r_sclk) begin
                        // rising SPICLK: the slave's bit has been stable all low phase
                        w_sclk = 1'b1;
                        w_rx   = {r_rx[6:0], MISO};
                    end else if (r_bit == 3'd7) begin
                        w_bit      = 3'd0;
                        w_rx_data  = r_rx;
                        w_rx_valid = 1'b1;
                        w_state    = r_last ? HOLD : WAIT_NEXT;
                    end else begin
                        w_bit  = r_bit + 3'd1;
                        w_sclk = 1'b0;
                        w_mosi = r_tx[7];
                        w_tx   = {r_tx[6:0], 1'b0};
                    end
                end
            end
            WAIT_NEXT: begin
                if (w_accept) begin
                    // no setup phase: SS is already low, start the first low phase now
                    w_state = SHIFT;
                    w_div   = 8'd0;
                    w_last  = txLast;
                    w_sclk  = 1'b0;
                    w_mosi  = txData[7];
                    w_tx    = {txData[6:0], 1'b0};
                end
            end
            HOLD: begin
                if (w_div_end) begin
                    w_state = GAP;
                    w_div   = 8'd0;
                    w_ss    = 1'b1;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            GAP: begin
                if (w_div_end) begin
                    w_state = IDLE;
                    w_div   = 8'd0;
                end else begin
                    w_div = r_div + 8'd1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx       <= 8'd0;
            r_rx       <= 8'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_last     <= 1'b0;
            r_sclk     <= 1'b1;
            r_mosi     <= 1'b0;
            r_ss       <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_div      <= w_div;
            r_bit      <= w_bit;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_last     <= w_last;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_ss       <= w_ss;
        end
    end

    assign txReady = w_ready;
    assign rxData  = r_rx_data;
    assign rxValid = r_rx_valid;
    assign busy    = (r_state != IDLE);
    assign SPICLK  = r_sclk;
    assign MOSI    = r_mosi;
    assign SS      = r_ss;

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning SPICLK half-period in sysClk cycles; legal range 2..255.
REQ-002 SHALL have port sysClk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port txValid  input  1  host offers a byte.
REQ-005 SHALL have port txData  input  8  byte to send on MOSI.
REQ-006 SHALL have port txLast  input  1  offered byte ends the transaction.
REQ-007 SHALL have port txReady  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port rxData  output  8  byte captured from MISO.
REQ-009 SHALL have port rxValid  output  1  one-cycle strobe; rxData is new.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port SPICLK  output  1  SPI clock; idles high (CPOL=1).
REQ-012 SHALL have port MOSI  output  1  serial data to slave.
REQ-013 SHALL have port MISO  input  1  serial data from slave.
REQ-014 SHALL have port SS  output  1  slave select, active-low.

Function
REQ-015 SHALL use SPI mode 3, MSB first: MOSI changes on the SPICLK falling transition, MISO sampled on the SPICLK rising transition.
REQ-016 SHALL implement states IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD, GAP.
REQ-017 SHALL assert txReady only in IDLE and WAIT_NEXT, never while rst is high.
REQ-018 SHALL accept a byte on the cycle txValid and txReady are both high, latching txData and txLast.
REQ-019 SHALL ignore txValid whenever txReady is low, with no latch and no state change.
REQ-020 IDLE accept: SHALL go to SETUP, drive SS low on the next cycle, and hold SETUP for CLK_DIV cycles with SPICLK high.
REQ-021 SHIFT, per bit: SHALL drive SPICLK low for CLK_DIV cycles, then high for CLK_DIV cycles; 8 bits take 16*CLK_DIV cycles.
REQ-022 SHALL drive MOSI, on the cycle SPICLK goes low, with the next bit (bit 7 first).
REQ-023 SHALL register MISO into the receive shift register on the sysClk edge that drives SPICLK high.
REQ-024 At the end of the 8th high phase, SHALL load rxData and pulse rxValid for exactly one cycle.
REQ-025 On that rxValid cycle, SHALL enter HOLD if the latched txLast=1, else WAIT_NEXT.
REQ-026 WAIT_NEXT: SHALL keep SS low and SPICLK high indefinitely, with txReady=1.
REQ-027 WAIT_NEXT accept: SHALL go directly to SHIFT, with no SETUP.
REQ-028 HOLD: SHALL keep SS low for CLK_DIV cycles, then drive SS high and enter GAP.
REQ-029 GAP: SHALL keep SS high for CLK_DIV cycles with txReady=0, then return to IDLE.
REQ-030 Latency: an IDLE accept at edge t0 SHALL give rxValid high in cycle t0+1+17*CLK_DIV; a WAIT_NEXT accept at t1 SHALL give rxValid high at t1+1+16*CLK_DIV.
REQ-031 Counters: SHALL use an 8-bit divider counting 0..CLK_DIV-1 that wraps at phase end, and a 3-bit bit counter that wraps 7->0 at byte end.
REQ-032 SHALL keep SPICLK high outside SHIFT.
REQ-033 SHALL hold MOSI at its last value outside SHIFT.

Reset
REQ-034 While rst is high, SHALL force state=IDLE, SS=1, SPICLK=1, MOSI=0, rxData=0x00, rxValid=0, busy=0, txReady=0, and clear all counters.
REQ-035 Reset asserted mid-transaction SHALL abort on the next edge with no rxValid and SS high immediately.
REQ-036 After reset, txReady SHALL be 1 in the first cycle after rst falls.

Verification
REQ-037 Single byte, CLK_DIV=4: txData=0x31, txLast=1, MISO loopback from MOSI -> MOSI bits 0,0,1,1,0,0,0,1; rxValid at t0+69 with rxData=0x31; SS high at t0+73; txReady high at t0+77.
REQ-038 Burst of 0x12, 0xD0, 0xCA with txLast on the last byte, slave model returning 0xA5, 0x5A, 0xFF -> SS low continuously; three rxValid pulses with those values; 0xD0 rxValid exactly 1+16*4 cycles after its accept.
REQ-039 txValid held high during SHIFT with changing txData -> no extra accept; transmitted byte unchanged.
REQ-040 rst pulsed at bit 4 of a byte -> next cycle SS=1, SPICLK=1, MOSI=0; no rxValid; a new transaction afterwards behaves per REQ-037.
REQ-041 CLK_DIV=2, WAIT_NEXT held 100 cycles before the next txValid -> SS stays low, SPICLK stays high, no spurious edges; the next byte completes normally.
REQ-042 Checker: each SPICLK high/low phase lasts exactly CLK_DIV cycles; MOSI never changes while SPICLK is high; exactly 8 rising edges per byte.
